// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter and sequencer for the shared data memory
module dmem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a_req,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wd,
  output logic          a_ack,
  output logic [DW-1:0] a_rd,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wd,
  output logic          b_ack,
  output logic [DW-1:0] b_rd,
  output logic          err,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] wd,
  input  logic [DW-1:0] rd,
  input  logic          state
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} fsm_t;

  fsm_t          fsm, fsm_next;
  logic          last_grant;   // 0 = A, 1 = B
  logic          gnt_b;
  logic          we_q;
  logic [7:0]    cnt;
  logic          win_b;
  logic          hit_limit;
  logic          finish;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wd;
  logic [DW-1:0] cap_data;

  always_comb begin
    fsm_next  = fsm;
    win_b     = 1'b0;
    hit_limit = (cnt == 8'(TIMEOUT - 1));
    finish    = state || hit_limit;
    if (a_req && b_req) win_b = ~last_grant;
    else                win_b = b_req;
    sel_we    = win_b ? b_we   : a_we;
    sel_addr  = win_b ? b_addr : a_addr;
    sel_wd    = win_b ? b_wd   : a_wd;
    // A timed-out access or any write returns zero data.
    cap_data  = (state && !we_q) ? rd : '0;
    case (fsm)
      IDLE:    if (a_req || b_req) fsm_next = ACCESS;
      ACCESS:  if (finish) fsm_next = DONE;
      DONE:    fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm        <= IDLE;
      last_grant <= 1'b1;
      gnt_b      <= 1'b0;
      we_q       <= 1'b0;
      cnt        <= '0;
      MemRead    <= 1'b0;
      MemWrite   <= 1'b0;
      addr       <= '0;
      wd         <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      err        <= 1'b0;
      a_rd       <= '0;
      b_rd       <= '0;
    end else begin
      fsm   <= fsm_next;
      a_ack <= 1'b0;
      b_ack <= 1'b0;
      err   <= 1'b0;
      case (fsm)
        IDLE: begin
          if (a_req || b_req) begin
            gnt_b      <= win_b;
            last_grant <= win_b;
            we_q       <= sel_we;
            addr       <= sel_addr;
            wd         <= sel_wd;
            MemRead    <= ~sel_we;
            MemWrite   <= sel_we;
            cnt        <= '0;
          end
        end
        ACCESS: begin
          if (finish) begin
            MemRead  <= 1'b0;
            MemWrite <= 1'b0;
            cnt      <= '0;
            // Completion strobe wins over the watchdog in the same cycle.
            err      <= ~state;
            if (gnt_b) begin
              b_ack <= 1'b1;
              b_rd  <= cap_data;
            end else begin
              a_ack <= 1'b1;
              a_rd  <= cap_data;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [31:0] a_addr = '0, a_wd = '0, b_addr = '0, b_wd = '0;
  logic        a_ack, b_ack, err, MemRead, MemWrite;
  logic [31:0] a_rd, b_rd, addr, wd;
  logic [31:0] rd = '0;
  logic        state = 1'b0;

  int checks   = 0;
  int failures = 0;
  int cyc;
  bit ok;

  dmem_arbiter #(.AW(32), .DW(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wd(a_wd), .a_ack(a_ack), .a_rd(a_rd),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wd(b_wd), .b_ack(b_ack), .b_rd(b_rd),
    .err(err), .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr), .wd(wd),
    .rd(rd), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Issue one request and play the memory: state is raised on ACCESS cycle lat (0 = never).
  task automatic access(input bit port_b, input bit we, input logic [31:0] ad,
                        input logic [31:0] d, input int lat, input logic [31:0] mrd,
                        output int cmd_cycles, output bit acked);
    if (port_b) begin
      b_req = 1'b1; b_we = we; b_addr = ad; b_wd = d;
    end else begin
      a_req = 1'b1; a_we = we; a_addr = ad; a_wd = d;
    end
    state = 1'b0;
    rd = mrd;
    cmd_cycles = 0;
    acked = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (a_ack || b_ack) begin
        acked = 1'b1;
        break;
      end
      if (MemRead || MemWrite) begin
        cmd_cycles++;
        chk("cmd_addr", addr, ad);
        chk("cmd_wd", wd, d);
        chk("cmd_kind", {MemRead, MemWrite}, {~we, we});
        state = (cmd_cycles == lat);
      end
    end
    state = 1'b0;
    chk("ack_seen", acked, 1'b1);
  endtask

  task automatic release_all;
    a_req = 1'b0;
    b_req = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    tick;
    tick;
    rst = 1'b0;
    chk("rst_memread", MemRead, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_addr", addr, 0);
    chk("rst_wd", wd, 0);
    chk("rst_acks", {a_ack, b_ack, err}, 0);
    chk("rst_rd", {a_rd, b_rd}, 0);

    // Single zero-wait read on A
    access(1'b0, 1'b0, 32'h10, 32'h0, 1, 32'h12345678, cyc, ok);
    chk("rd_cmd_cycles", cyc, 1);
    chk("rd_a_ack", a_ack, 1);
    chk("rd_a_rd", a_rd, 32'h12345678);
    chk("rd_b_ack", b_ack, 0);
    chk("rd_err", err, 0);
    chk("rd_cmd_off", {MemRead, MemWrite}, 0);
    release_all;
    chk("rd_ack_pulse", a_ack, 0);

    // Slow write on B
    access(1'b1, 1'b1, 32'h20, 32'hCAFEF00D, 4, 32'hFFFFFFFF, cyc, ok);
    chk("wr_cmd_cycles", cyc, 4);
    chk("wr_b_ack", b_ack, 1);
    chk("wr_err", err, 0);
    chk("wr_b_rd", b_rd, 0);
    chk("wr_a_rd_hold", a_rd, 32'h12345678);
    release_all;

    // Contention, zero-wait memory: expect A,B,A,B
    a_we = 1'b0; b_we = 1'b0; a_addr = 32'h100; b_addr = 32'h200;
    a_req = 1'b1; b_req = 1'b1;
    state = 1'b1; rd = 32'h55;
    for (int g = 0; g < 4; g++) begin
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        tick;
        chk("rr_one_hot", MemRead & MemWrite, 0);
        if (a_ack || b_ack) begin
          ok = 1'b1;
          break;
        end
      end
      chk("rr_ack_seen", ok, 1);
      chk("rr_grant_b", {a_ack, b_ack}, (g % 2) ? 2'b01 : 2'b10);
      if (a_ack) a_req = 1'b0;
      else       b_req = 1'b0;
      tick;
      a_req = 1'b1;
      b_req = 1'b1;
    end
    state = 1'b0;
    release_all;
    tick;
    tick;

    // Watchdog: memory never completes
    access(1'b0, 1'b0, 32'h30, 32'h0, 0, 32'h99, cyc, ok);
    chk("to_cmd_cycles", cyc, 16);
    chk("to_a_ack", a_ack, 1);
    chk("to_err", err, 1);
    chk("to_a_rd", a_rd, 0);
    release_all;
    chk("to_err_pulse", err, 0);
    access(1'b0, 1'b0, 32'h34, 32'h0, 1, 32'hDEADBEEF, cyc, ok);
    chk("post_to_err", err, 0);
    chk("post_to_a_rd", a_rd, 32'hDEADBEEF);
    release_all;

    // Completion on the last allowed cycle beats the watchdog
    access(1'b1, 1'b0, 32'h40, 32'h0, 16, 32'h0BADF00D, cyc, ok);
    chk("tie_cmd_cycles", cyc, 16);
    chk("tie_b_ack", b_ack, 1);
    chk("tie_err", err, 0);
    chk("tie_b_rd", b_rd, 32'h0BADF00D);
    release_all;

    // Async reset in the middle of an access
    a_req = 1'b1; a_we = 1'b0; a_addr = 32'h50; state = 1'b0;
    tick;
    tick;
    chk("rst_mid_pre", MemRead, 1);
    #1 rst = 1'b1;
    #1 chk("rst_mid_drop", {MemRead, MemWrite}, 0);
    #1 rst = 1'b0;
    chk("rst_mid_no_ack", {a_ack, b_ack}, 0);
    access(1'b0, 1'b0, 32'h50, 32'h0, 1, 32'h77, cyc, ok);
    chk("rst_regrant_cycles", cyc, 1);
    chk("rst_regrant_rd", a_rd, 32'h77);
    release_all;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
